// File: rtl/shift_register_universal.sv
// Universal shift register: hold / shift up / shift down / parallel load, with a frame counter.
// Optional circular shifting via the `rotate` input when ROTATE_SHIFT_EN is defined.
module shift_register_universal #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CNT_W       = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
`ifdef ROTATE_SHIFT_EN
    input  logic             rotate,
`endif
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CNT_W-1:0] shift_count,
    output logic             frame_done
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic fill_up;
    logic fill_down;
    logic is_shift;

    // Bit entering the vacated end: serial input, or the bit falling off the other end when rotating.
`ifdef ROTATE_SHIFT_EN
    assign fill_up   = rotate ? q[WIDTH-1] : sin_lsb;
    assign fill_down = rotate ? q[0]       : sin_msb;
`else
    assign fill_up   = sin_lsb;
    assign fill_down = sin_msb;
`endif

    assign is_shift = enable && (mode == MODE_UP || mode == MODE_DOWN);
    assign sout_msb = q[WIDTH-1];
    assign sout_lsb = q[0];

    always_ff @(posedge clock) begin
        if (clear) begin
            q           <= RESET_VALUE;
            shift_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (enable) begin
                case (mode)
                    MODE_UP:   q <= {q[WIDTH-2:0], fill_up};
                    MODE_DOWN: q <= {fill_down, q[WIDTH-1:1]};
                    MODE_LOAD: begin
                        q           <= load_data;
                        shift_count <= '0;
                    end
                    default:   q <= q;
                endcase
            end
            // Direction is irrelevant to framing; every shift edge advances the count.
            if (is_shift) begin
                if (shift_count == CNT_LAST) begin
                    shift_count <= '0;
                    frame_done  <= 1'b1;
                end else begin
                    shift_count <= shift_count + 1'b1;
                end
            end
        end
    end

endmodule
